cfg_frame_tx: RTL and testbench

Serializer that builds the 27-bit state-table configuration frame and drives it, one bit per clock, onto the serial REG_STATE line of the FSM look-at-table core. It is the transmit end of the serial-to-parallel configuration loader. It captures five 5-bit jump entries plus a 2-bit clock-select field in parallel on a start handshake. It issues a receiver-sync pulse, then shifts the frame out MSB first and reports completion. It sits between the host/test controller and the REG_STATE pin of the table core, on the same clock.

---
 rtl/cfg_frame_tx_if.sv | 26 ++
 rtl/cfg_frame_tx.sv | 111 +++++++++++
 tb/tb_cfg_frame_tx.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cfg_frame_tx_if.sv
// Parallel-load / serial-out handshake bundle between the host controller
// and the configuration frame serializer.
interface cfg_frame_tx_if;
  logic       start;
  logic [4:0] jump1;
  logic [4:0] jump2;
  logic [4:0] jump3;
  logic [4:0] jump4;
  logic [4:0] jump5;
  logic [1:0] clk_sel;
  logic       ready;
  logic       busy;
  logic       rx_rst_n;
  logic       ser_out;
  logic       done;

  modport master (
    output start, jump1, jump2, jump3, jump4, jump5, clk_sel,
    input  ready, busy, rx_rst_n, ser_out, done
  );

  modport slave (
    input  start, jump1, jump2, jump3, jump4, jump5, clk_sel,
    output ready, busy, rx_rst_n, ser_out, done
  );
endinterface

// File: rtl/cfg_frame_tx.sv
// Builds the 27-bit state-table configuration frame, pulses the receiver's
// reset for SYNC_CYC cycles, then shifts the frame out MSB first.
module cfg_frame_tx #(
  parameter int SYNC_CYC = 2,
  parameter int FRAME_W  = 27
) (
  input  logic          clk,
  input  logic          reset,
  cfg_frame_tx_if.slave bus
);

  localparam logic [4:0] BIT_LAST  = 5'(FRAME_W - 1);
  localparam logic [3:0] SYNC_LAST = 4'(SYNC_CYC - 1);

  typedef enum logic [1:0] {IDLE, SYNC, SHIFT, DONE} state_t;

  state_t               state_reg,    state_next;
  logic [FRAME_W-1:0]   shift_reg,    shift_next;
  logic [4:0]           bit_cnt_reg,  bit_cnt_next;
  logic [3:0]           sync_cnt_reg, sync_cnt_next;

  logic ready_reg,    ready_next;
  logic busy_reg,     busy_next;
  logic rx_rst_n_reg, rx_rst_n_next;
  logic ser_out_reg,  ser_out_next;
  logic done_reg,     done_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      sync_cnt_reg <= '0;
      ready_reg    <= 1'b1;
      busy_reg     <= 1'b0;
      rx_rst_n_reg <= 1'b1;
      ser_out_reg  <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      sync_cnt_reg <= sync_cnt_next;
      ready_reg    <= ready_next;
      busy_reg     <= busy_next;
      rx_rst_n_reg <= rx_rst_n_next;
      ser_out_reg  <= ser_out_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    sync_cnt_next = sync_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          shift_next    = {bus.clk_sel, bus.jump5, bus.jump4,
                           bus.jump3, bus.jump2, bus.jump1};
          bit_cnt_next  = '0;
          sync_cnt_next = '0;
          state_next    = SYNC;
        end
      end
      SYNC: begin
        if (sync_cnt_reg == SYNC_LAST) begin
          sync_cnt_next = '0;
          state_next    = SHIFT;
        end else begin
          sync_cnt_next = sync_cnt_reg + 4'd1;
        end
      end
      SHIFT: begin
        shift_next = {shift_reg[FRAME_W-2:0], 1'b0};
        if (bit_cnt_reg == BIT_LAST) begin
          bit_cnt_next = '0;
          state_next   = DONE;
        end else begin
          bit_cnt_next = bit_cnt_reg + 5'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so each output is aligned
  // with the state it describes; in SHIFT the MSB of the updated shift
  // register is the bit the receiver samples on the following edge.
  always_comb begin
    ready_next    = (state_next == IDLE);
    busy_next     = (state_next != IDLE);
    rx_rst_n_next = (state_next != SYNC);
    done_next     = (state_next == DONE);
    ser_out_next  = (state_next == SHIFT) ? shift_next[FRAME_W-1] : 1'b0;
  end

  assign bus.ready    = ready_reg;
  assign bus.busy     = busy_reg;
  assign bus.rx_rst_n = rx_rst_n_reg;
  assign bus.ser_out  = ser_out_reg;
  assign bus.done     = done_reg;

endmodule

// File: tb/tb_cfg_frame_tx.sv
// Self-checking bench for cfg_frame_tx: frame table, corner-case sequences
// and randomized traffic against a cycle-offset reference model.
module tb_cfg_frame_tx;

  localparam int SC = 2;

  typedef struct {
    logic [4:0]  j1, j2, j3, j4, j5;
    logic [1:0]  cs;
    logic [26:0] exp_frame;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc_n = 0;

  // Reference model: mk = cycles since acceptance (0 = idle)
  int          mk = 0;
  logic [26:0] frame_m = '0;
  logic [26:0] cap = '0;
  logic [26:0] last_cap = '0;

  // Behavioural SIPO receiver driven by the serializer outputs
  logic [26:0] rx_sr = '0;
  int          rx_cnt = 0;

  cfg_frame_tx_if bus();

  cfg_frame_tx #(.SYNC_CYC(SC), .FRAME_W(27)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d mk=%0d got %0b want %0b", name, cyc_n, mk, act, exp);
    end
  endtask

  task automatic chk27(input string name, input logic [26:0] act, input logic [26:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got %07h want %07h", name, cyc_n, act, exp);
    end
  endtask

  // Sample the values the next rising edge will see, compare with the model,
  // then drive the inputs for that edge.
  task automatic step(input logic st, input logic [4:0] a, b, c, d, e,
                      input logic [1:0] cs);
    logic e_ser, e_rx, e_busy, e_ready, e_done;
    @(negedge clk);
    cyc_n++;
    e_ser = 1'b0; e_rx = 1'b1; e_busy = 1'b0; e_ready = 1'b1; e_done = 1'b0;
    if (mk >= 1 && mk <= SC) begin
      e_rx = 1'b0; e_busy = 1'b1; e_ready = 1'b0;
    end else if (mk >= SC + 1 && mk <= SC + 27) begin
      e_ser = frame_m[26 - (mk - SC - 1)]; e_busy = 1'b1; e_ready = 1'b0;
    end else if (mk == SC + 28) begin
      e_done = 1'b1; e_busy = 1'b1; e_ready = 1'b0;
    end
    chk("ser_out",  bus.ser_out,  e_ser);
    chk("rx_rst_n", bus.rx_rst_n, e_rx);
    chk("busy",     bus.busy,     e_busy);
    chk("ready",    bus.ready,    e_ready);
    chk("done",     bus.done,     e_done);

    if (mk >= SC + 1 && mk <= SC + 27) cap = {cap[25:0], bus.ser_out};
    if (mk == SC + 28) begin
      last_cap = cap;
      chk27("frame_model", cap, frame_m);
    end

    if (!bus.rx_rst_n) begin
      rx_sr = '0; rx_cnt = 0;
    end else if (rx_cnt < 27) begin
      rx_sr = {rx_sr[25:0], bus.ser_out}; rx_cnt++;
    end

    bus.start = st; bus.jump1 = a; bus.jump2 = b; bus.jump3 = c;
    bus.jump4 = d; bus.jump5 = e; bus.clk_sel = cs;

    if (!reset) mk = 0;
    else if (mk == 0) begin
      if (st) begin frame_m = {cs, e, d, c, b, a}; mk = 1; end
    end else if (mk == SC + 28) mk = 0;
    else mk++;
  endtask

  task automatic send(input vec_t v);
    step(1'b1, v.j1, v.j2, v.j3, v.j4, v.j5, v.cs);
    for (int i = 0; i < 100 && mk != 0; i++)
      step(1'b0, v.j1, v.j2, v.j3, v.j4, v.j5, v.cs);
  endtask

  vec_t vecs[5];
  int   done_cyc[$];
  int   nrand;

  initial begin
    bus.start = 1'b0; bus.jump1 = '0; bus.jump2 = '0; bus.jump3 = '0;
    bus.jump4 = '0; bus.jump5 = '0; bus.clk_sel = '0;

    vecs[0] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 2'b10, 27'b10_00101_00100_00011_00010_00001};
    vecs[1] = '{5'h1F, 5'h00, 5'h15, 5'h0A, 5'h11, 2'b01, 27'b01_10001_01010_10101_00000_11111};
    vecs[2] = '{5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 2'b11, 27'h7FF_FFFF};
    vecs[3] = '{5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 2'b11, 27'h600_0000};
    vecs[4] = '{5'h0A, 5'h15, 5'h0A, 5'h15, 5'h0A, 2'b10, 27'b10_01010_10101_01010_10101_01010};

    // Reset held for 3 cycles, start asserted must be ignored meanwhile
    for (int i = 0; i < 3; i++) step(1'b1, '1, '1, '1, '1, '1, 2'b11);
    bus.start = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0, '0, '0, 2'b00);

    // Frame table with loopback into the receiver model
    for (int i = 0; i < 5; i++) begin
      send(vecs[i]);
      chk27("table_frame", last_cap, vecs[i].exp_frame);
      checks++;
      if (rx_cnt != 27 || rx_sr[4:0] !== vecs[i].j1 || rx_sr[9:5] !== vecs[i].j2 ||
          rx_sr[14:10] !== vecs[i].j3 || rx_sr[19:15] !== vecs[i].j4 ||
          rx_sr[24:20] !== vecs[i].j5 || rx_sr[26:25] !== vecs[i].cs) begin
        errors++;
        $display("FAIL loopback vec=%0d got cnt=%0d sr=%07h want sr=%07h",
                 i, rx_cnt, rx_sr, vecs[i].exp_frame);
      end
      step(1'b0, '0, '0, '0, '0, '0, 2'b00);
    end

    // Input isolation: start and inputs churn while a frame is in flight
    step(1'b1, vecs[0].j1, vecs[0].j2, vecs[0].j3, vecs[0].j4, vecs[0].j5, vecs[0].cs);
    for (int i = 0; i < 100 && mk != 0; i++)
      step(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), 2'($urandom));
    step(1'b0, '0, '0, '0, '0, '0, 2'b00);
    chk27("isolation_frame", last_cap, vecs[0].exp_frame);

    // Mid-frame reset at cycle 15, then a clean frame
    step(1'b1, vecs[1].j1, vecs[1].j2, vecs[1].j3, vecs[1].j4, vecs[1].j5, vecs[1].cs);
    for (int i = 0; i < 40 && mk != 15; i++) step(1'b0, '0, '0, '0, '0, '0, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    mk = 0;
    #1;
    chk("rst_ser_out",  bus.ser_out,  1'b0);
    chk("rst_busy",     bus.busy,     1'b0);
    chk("rst_rx_rst_n", bus.rx_rst_n, 1'b1);
    chk("rst_done",     bus.done,     1'b0);
    chk("rst_ready",    bus.ready,    1'b1);
    step(1'b0, '0, '0, '0, '0, '0, 2'b00);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0, '0, '0, 2'b00);
    send(vecs[4]);
    chk27("post_reset_frame", last_cap, vecs[4].exp_frame);

    // Back-to-back with start held high and all-ones inputs
    for (int i = 0; i < 3 * 31 + 4; i++) begin
      step(1'b1, '1, '1, '1, '1, '1, 2'b11);
      if (bus.done) begin
        done_cyc.push_back(cyc_n);
        chk27("b2b_ones", last_cap, 27'h7FF_FFFF);
      end
    end
    step(1'b0, '0, '0, '0, '0, '0, 2'b00);
    checks++;
    if (done_cyc.size() < 3) begin
      errors++;
      $display("FAIL b2b_done_count got %0d want >=3", done_cyc.size());
    end
    for (int i = 1; i < done_cyc.size(); i++) begin
      checks++;
      if (done_cyc[i] - done_cyc[i-1] != SC + 29) begin
        errors++;
        $display("FAIL b2b_spacing got %0d want %0d", done_cyc[i] - done_cyc[i-1], SC + 29);
      end
    end
    for (int i = 0; i < 40 && mk != 0; i++) step(1'b0, '0, '0, '0, '0, '0, 2'b00);

    // Randomized traffic
    nrand = 600;
    for (int i = 0; i < nrand; i++)
      step($urandom_range(0, 7) == 0, 5'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), 5'($urandom), 2'($urandom));
    for (int i = 0; i < 40 && mk != 0; i++) step(1'b0, '0, '0, '0, '0, '0, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
